// File: rtl/rs_encoder_pkg.sv
// Shared constants, types and GF(2^8) helpers for the RS(255,239) encoder.
package rs_encoder_pkg;

  localparam int N     = 255;           // codeword length (symbols)
  localparam int K     = 239;           // message length (symbols)
  localparam int T     = 8;             // correction capability
  localparam int M     = 8;             // symbol width (bits)
  localparam int NPAR  = 2 * T;         // parity symbols, equals N-K
  localparam int CNT_W = $clog2(N);
  localparam int FCR   = 0;             // first consecutive root, shared with the syndrome block

  localparam logic [M:0] PRIM_POLY = 9'h11D;

  typedef logic [M-1:0] sym_t;
  typedef logic [NPAR-1:0][M-1:0] gen_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MSG    = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_K    = CNT_W'(K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // GF(2^m) multiply, Horner form over the bits of b (MSB first).
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? PRIM_POLY[M-1:0] : sym_t'(0));
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  function automatic sym_t gf_alpha_pow(input int e);
    sym_t r;
    r = sym_t'(1);
    for (int i = 0; i < e; i++) r = gf_mul(r, sym_t'(2));
    return r;
  endfunction

  // g(x) = prod_{i=0..2t-1} (x + a^(FCR+i)); the monic top coefficient is implied.
  function automatic gen_t gen_poly();
    logic [NPAR:0][M-1:0] g;
    sym_t                 root;
    gen_t                 res;
    g    = '0;
    g[0] = sym_t'(1);
    root = gf_alpha_pow(FCR);
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, sym_t'(2));
    end
    for (int j = 0; j < NPAR; j++) res[j] = g[j];
    return res;
  endfunction

  localparam gen_t G = gen_poly();

endpackage

// File: rtl/rs_encoder_if.sv
// Message-in / codeword-out handshake bundle of the RS encoder.
interface rs_encoder_if
  import rs_encoder_pkg::*;
();

  logic msg_valid;
  sym_t msg_data;
  logic msg_ready;
  logic out_valid;
  sym_t out_data;
  logic out_sop;
  logic out_eop;

  // Source of messages and sink of codewords.
  modport master (
    output msg_valid, msg_data,
    input  msg_ready, out_valid, out_data, out_sop, out_eop
  );

  // The encoder itself.
  modport slave (
    input  msg_valid, msg_data,
    output msg_ready, out_valid, out_data, out_sop, out_eop
  );

endinterface

// File: rtl/rs_encoder_gf_const_mul.sv
// Multiply a GF(2^8) symbol by a constant; reduces to a small XOR network.
module rs_encoder_gf_const_mul
  import rs_encoder_pkg::*;
#(
  parameter sym_t C = '0
) (
  input  sym_t a_i,
  output sym_t p_o
);

  // Pure combinational product, no register inside the LFSR loop.
  assign p_o = gf_mul(a_i, C);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(255,239) encoder: echoes message symbols, then shifts out
// 2t parity symbols from an LFSR dividing x^(n-k)*M(x) by g(x).
module rs_encoder
  import rs_encoder_pkg::*;
(
  input logic         clk_in,
  input logic         sys_rst_n,
  rs_encoder_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sym_t             par_q [NPAR];
  sym_t             par_d [NPAR];
  logic             ready_q, ready_d;
  logic             out_valid_q, out_valid_d;
  sym_t             out_data_q, out_data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;

  logic xfer;
  sym_t fb;
  sym_t prod [NPAR];

  assign xfer = bus.msg_valid & ready_q;
  assign fb   = bus.msg_data ^ par_q[NPAR-1];

  for (genvar j = 0; j < NPAR; j++) begin : g_mul
    rs_encoder_gf_const_mul #(.C(G[j])) u_mul (
      .a_i (fb),
      .p_o (prod[j])
    );
  end

  // Next-state, LFSR and output-register logic for all three phases.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves one unassigned (no latches);
    // combinational blocks use blocking '=', the clocked block below uses '<='.
    state_d     = state_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    ready_d     = ready_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_MSG: begin
        ready_d = 1'b1;
        if (xfer) begin
          par_d[0] = prod[0];
          for (int j = 1; j < NPAR; j++) par_d[j] = par_q[j-1] ^ prod[j];
          cnt_d       = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          out_data_d  = bus.msg_data;
          sop_d       = (state_q == ST_IDLE);
          if (cnt_d == CNT_K) begin
            state_d = ST_PARITY;
            ready_d = 1'b0;
          end else begin
            state_d = ST_MSG;
          end
        end
      end

      ST_PARITY: begin
        ready_d     = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = par_q[NPAR-1];
        par_d[0]    = '0;
        for (int j = 1; j < NPAR; j++) par_d[j] = par_q[j-1];
        if (cnt_q == CNT_LAST) begin
          // Last parity leaves now; the LFSR has drained to zero for the next frame.
          cnt_d   = '0;
          eop_d   = 1'b1;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, LFSR and registered outputs; synchronous reset abandons any frame.
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      // NOTE: the parity bank is reset on purpose: IDLE relies on an all-zero LFSR
      // as the starting remainder, and a mid-frame reset must not leak partial parity.
      for (int j = 0; j < NPAR; j++) par_q[j] <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      for (int j = 0; j < NPAR; j++) par_q[j] <= par_d[j];
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

  assign bus.msg_ready = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = sop_q;
  assign bus.out_eop   = eop_q;

endmodule
